// File: rtl/jt6295_cmd_seq_pkg.sv
// Shared types and constants for the JT6295 command sequencer.
package jt6295_cmd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_CH,
    FETCH,
    HOLD
  } state_t;

  localparam int unsigned TBL_ENTRY_BYTES = 6;
  localparam int unsigned TBL_STRIDE_LOG2 = 3;
  localparam int unsigned CMD_PHRASE_BIT  = 7;

  // Byte address of a phrase-table entry; wraps modulo 2^18.
  function automatic logic [17:0] tbl_entry_addr(input logic [17:0] base,
                                                 input logic [6:0]  phrase);
    return base + (18'(phrase) << TBL_STRIDE_LOG2);
  endfunction

endpackage

// File: rtl/jt6295_cmd_seq_if.sv
// CPU command bus and phrase-table ROM port of the JT6295 command sequencer.
interface jt6295_cmd_seq_if;
  logic        cpu_we;
  logic [7:0]  cpu_din;
  logic        cmd_busy;
  logic        rom_cs;
  logic [17:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_ok;

  modport master (
    output cpu_we, cpu_din, rom_data, rom_ok,
    input  cmd_busy, rom_cs, rom_addr
  );

  modport slave (
    input  cpu_we, cpu_din, rom_data, rom_ok,
    output cmd_busy, rom_cs, rom_addr
  );
endinterface

// File: rtl/jt6295_cmd_seq_tbl_fetch.sv
// Sequential 6-byte phrase-table reader with rom_ok handshake.
// Optional per-byte fetch timeout under JT6295_ROM_TIMEOUT_EN.
module jt6295_tbl_fetch
  import jt6295_cmd_seq_pkg::*;
#(
  parameter logic [17:0] TBL_BASE = 18'h0,
  parameter logic [7:0]  TOUT     = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_go,
  input  logic [6:0]  i_phrase,
  output logic        o_rom_cs,
  output logic [17:0] o_rom_addr,
  input  logic [7:0]  i_rom_data,
  input  logic        i_rom_ok,
  output logic [17:0] o_start_addr,
  output logic [17:0] o_stop_addr,
  output logic        o_done,
  output logic        o_abort,
  output logic        o_tout_err
);

  logic        r_busy;
  logic        r_settle;
  logic [2:0]  r_k;
  logic [17:0] r_addr;
  logic [17:0] r_start_addr;
  logic [17:0] r_stop_addr;

  logic w_cap;
  logic w_last;
  logic w_abort;

  // r_settle masks rom_ok on the cycle right after rom_addr moves.
  assign w_cap  = r_busy & ~r_settle & i_rom_ok;
  assign w_last = (r_k == 3'(TBL_ENTRY_BYTES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy       <= 1'b0;
      r_settle     <= 1'b0;
      r_k          <= '0;
      r_addr       <= '0;
      r_start_addr <= '0;
      r_stop_addr  <= '0;
    end else if (i_go) begin
      r_busy   <= 1'b1;
      r_settle <= 1'b1;
      r_k      <= '0;
      r_addr   <= tbl_entry_addr(TBL_BASE, i_phrase);
    end else if (r_busy) begin
      if (w_abort) begin
        r_busy <= 1'b0;
      end else if (w_cap) begin
        case (r_k)
          3'd0:    r_start_addr[17:16] <= i_rom_data[1:0];
          3'd1:    r_start_addr[15:8]  <= i_rom_data;
          3'd2:    r_start_addr[7:0]   <= i_rom_data;
          3'd3:    r_stop_addr[17:16]  <= i_rom_data[1:0];
          3'd4:    r_stop_addr[15:8]   <= i_rom_data;
          3'd5:    r_stop_addr[7:0]    <= i_rom_data;
          default: ;
        endcase
        if (w_last) begin
          r_busy <= 1'b0;
        end else begin
          r_k      <= r_k + 3'd1;
          r_addr   <= r_addr + 18'd1;
          r_settle <= 1'b1;
        end
      end else begin
        r_settle <= 1'b0;
      end
    end
  end

`ifdef JT6295_ROM_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       r_tout_err;

  // Counter restarts with every new byte address; abort lands after TOUT cycles.
  assign w_abort = r_busy & ~w_cap & (r_cnt == TOUT - 8'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_tout_err <= 1'b0;
    end else begin
      if (i_go || (w_cap && !w_last)) begin
        r_cnt <= '0;
      end else if (r_busy) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_abort) begin
        r_tout_err <= 1'b1;
      end
    end
  end

  assign o_tout_err = r_tout_err;
`else
  assign w_abort    = 1'b0;
  assign o_tout_err = 1'b0;
`endif

  assign o_rom_cs     = r_busy;
  assign o_rom_addr   = r_addr;
  assign o_start_addr = r_start_addr;
  assign o_stop_addr  = r_stop_addr;
  assign o_done       = w_cap & w_last;
  assign o_abort      = w_abort;

endmodule

// File: rtl/jt6295_cmd_seq.sv
// JT6295 CPU command sequencer: command decode, table fetch, start/stop hold.
// Optional ROM fetch timeout enabled by defining JT6295_ROM_TIMEOUT_EN.
module jt6295_cmd_seq
  import jt6295_cmd_seq_pkg::*;
#(
  parameter logic [17:0] TBL_BASE = 18'h0,
  parameter logic [7:0]  TOUT     = 8'd255
) (
  input  logic              rst,
  input  logic              clk,
  input  logic              cen,
  jt6295_cmd_seq_if.slave   bus,
  input  logic [3:0]        busy,
  output logic [17:0]       start_addr,
  output logic [17:0]       stop_addr,
  output logic [3:0]        att,
  output logic [3:0]        start,
  output logic [3:0]        stop,
  output logic              tout_err
);

  state_t     r_state;
  logic [6:0] r_phrase;
  logic [3:0] r_mask;
  logic [3:0] r_att;
  logic [3:0] r_start;
  logic [3:0] r_stop;

  logic       w_cmd_busy;
  logic       w_wr;
  logic       w_go;
  logic       w_done;
  logic       w_abort;
  logic [3:0] w_start_req;
  logic [3:0] w_stop_held;

  assign w_cmd_busy  = (r_state == FETCH) || (r_state == HOLD) ||
                       ((r_state == IDLE) && (r_stop != '0));
  assign w_wr        = bus.cpu_we & ~w_cmd_busy;
  assign w_go        = w_wr && (r_state == WAIT_CH) && (r_phrase != '0) &&
                       (bus.cpu_din[7:4] != '0);
  assign w_start_req = r_mask & ~busy;
  // A cen in the same cycle as a stop write retires only the older request.
  assign w_stop_held = cen ? '0 : r_stop;

  jt6295_tbl_fetch #(
    .TBL_BASE (TBL_BASE),
    .TOUT     (TOUT)
  ) u_fetch (
    .clk          (clk),
    .rst          (rst),
    .i_go         (w_go),
    .i_phrase     (r_phrase),
    .o_rom_cs     (bus.rom_cs),
    .o_rom_addr   (bus.rom_addr),
    .i_rom_data   (bus.rom_data),
    .i_rom_ok     (bus.rom_ok),
    .o_start_addr (start_addr),
    .o_stop_addr  (stop_addr),
    .o_done       (w_done),
    .o_abort      (w_abort),
    .o_tout_err   (tout_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_phrase <= '0;
      r_mask   <= '0;
      r_att    <= '0;
      r_start  <= '0;
      r_stop   <= '0;
    end else begin
      r_stop <= w_stop_held;
      case (r_state)
        IDLE: begin
          if (w_wr) begin
            if (bus.cpu_din[CMD_PHRASE_BIT]) begin
              r_phrase <= bus.cpu_din[6:0];
              r_state  <= WAIT_CH;
            end else begin
              r_stop  <= w_stop_held | bus.cpu_din[6:3];
              r_start <= r_start & ~bus.cpu_din[6:3];
            end
          end
        end
        WAIT_CH: begin
          if (w_wr) begin
            r_mask  <= bus.cpu_din[7:4];
            r_att   <= bus.cpu_din[3:0];
            r_state <= w_go ? FETCH : IDLE;
          end
        end
        FETCH: begin
          if (w_done) begin
            r_start <= w_start_req;
            r_state <= (w_start_req != '0) ? HOLD : IDLE;
          end else if (w_abort) begin
            r_state <= IDLE;
          end
        end
        HOLD: begin
          if (cen) begin
            r_start <= '0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_busy = w_cmd_busy;
  assign att          = r_att;
  assign start        = r_start;
  assign stop         = r_stop;

endmodule
